// File: rtl/f_decoder_func_if.sv
// Signal bundle for the registered decoder-based Boolean function block.
// The master drives the select inputs and enable; the slave returns the registered decode and o.
interface f_decoder_func_if;
   logic        en;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic [15:0] dec;
   logic        o;

   modport master (
      output en, a, b, c, d,
      input  dec, o
   );

   modport slave (
      input  en, a, b, c, d,
      output dec, o
   );
endinterface

// File: rtl/f_decoder_func.sv
// Registered four-input Boolean function: a 4-to-16 one-hot decoder whose lines are
// OR-ed through a static minterm mask. Both the decode and the function value register every edge.
module f_decoder_func #(
   parameter logic [15:0] MINTERMS = 16'h6996
) (
   input logic            clk,
   input logic            rst_n,
   f_decoder_func_if.slave bus
);

   logic [3:0]  idx;
   logic [15:0] dec_d, dec_q;
   logic        o_d, o_q;

   always_comb begin
      idx   = {bus.a, bus.b, bus.c, bus.d};
      dec_d = '0;
      for (int i = 0; i < 16; i++) begin
         dec_d[i] = bus.en & (idx == 4'(i));
      end
      // Function is formed by OR-ing the masked decode lines, not by muxing the mask.
      o_d = |(dec_d & MINTERMS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q <= '0;
         o_q   <= 1'b0;
      end else begin
         dec_q <= dec_d;
         o_q   <= o_d;
      end
   end

   assign bus.dec = dec_q;
   assign bus.o   = o_q;

endmodule

// File: tb/tb_f_decoder_func.sv
// Self-checking bench: four instances with different masks share one stimulus stream;
// expected results are queued when driven and compared after the capturing edge.
module tb_f_decoder_func;

   localparam logic [15:0] MASKS [4] = '{16'h6996, 16'h8000, 16'h0000, 16'hFFFF};

   typedef struct packed {
      logic [15:0] dec;
      logic [3:0]  o;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en, a, b, c, d;
   logic [15:0] dec_all [4];
   logic [3:0]  o_all;

   exp_t sb [$];
   exp_t prev;
   int   n_pass;
   int   n_total;

   f_decoder_func_if bus [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_dut
      f_decoder_func #(
         .MINTERMS (MASKS[g])
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus[g])
      );
      assign bus[g].en  = en;
      assign bus[g].a   = a;
      assign bus[g].b   = b;
      assign bus[g].c   = c;
      assign bus[g].d   = d;
      assign dec_all[g] = bus[g].dec;
      assign o_all[g]   = bus[g].o;
   end

   initial begin
      clk = 1'b0;
      forever #25 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic check_outputs(input string tag, input exp_t x);
      for (int g = 0; g < 4; g++) begin
         check($sformatf("%s dec[m%0d]", tag, g), dec_all[g], x.dec);
         check($sformatf("%s o[m%0d]", tag, g), {15'd0, o_all[g]}, {15'd0, x.o[g]});
      end
   endtask

   // Drive one evaluation, confirm outputs hold mid-cycle, then compare after the edge.
   task automatic step(input logic e, input logic [3:0] idx);
      exp_t        x;
      logic [15:0] m;
      en           = e;
      {a, b, c, d} = idx;
      x.dec        = e ? (16'd1 << idx) : 16'd0;
      for (int g = 0; g < 4; g++) begin
         m        = MASKS[g];
         x.o[g]   = e & m[idx];
      end
      sb.push_back(x);
      #10;
      check_outputs($sformatf("hold idx%0d", idx), prev);
      @(posedge clk);
      #1;
      prev = sb.pop_front();
      check_outputs($sformatf("en%0d idx%0d", e, idx), prev);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      prev    = '0;
      rst_n   = 1'b0;
      en      = 1'b1;
      {a, b, c, d} = 4'hF;

      // Held in reset with active inputs while clocking.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_outputs($sformatf("reset hold %0d", k), prev);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) step(1'b1, 4'(i));

      step(1'b0, 4'd7);
      step(1'b1, 4'd7);

      step(1'b1, 4'd0);
      step(1'b1, 4'd1);
      step(1'b1, 4'd0);

      for (int i = 0; i < 14; i++) step(1'b1, 4'(i));
      #10;
      rst_n = 1'b0;
      #1;
      prev = '0;
      check_outputs("async reset", prev);
      @(posedge clk);
      #1;
      check_outputs("reset edge", prev);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 4'd2);
      step(1'b1, 4'd15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
